// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin owner of the single VGA adaptor write port.
// Four draw clients (0 background, 1 cars, 2 towers, 3 lasers) request the
// port. The winner holds it until it signals done, drops its request, or the
// hold watchdog expires. Every ownership change is separated by one idle GAP
// cycle.
//
// Ports:
//   clk, resetn            clock, asynchronous active-low reset
//   req[3:0]               per-client draw request
//   done[3:0]              per-client end-of-burst pulse (owner only)
//   cli_wren[3:0]          per-client pixel write enable
//   cli_coord[59:0]        client i coordinate at [15i+14:15i], {x[7:0], y[6:0]}
//   cli_colour[35:0]       client i colour at [9i+8:9i]
//   grant[3:0]             registered one-hot (or zero) ownership
//   vga_wren/coord/colour  owner's write port, combinational pass-through
//   busy                   state is not IDLE
//   overrun                sticky: an owner was force-released by the watchdog
module vga_draw_arbiter #(
    parameter logic [15:0] MAX_HOLD = 16'd20000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [3:0]  req,
    input  logic [3:0]  done,
    input  logic [3:0]  cli_wren,
    input  logic [59:0] cli_coord,
    input  logic [35:0] cli_colour,
    output logic [3:0]  grant,
    output logic        vga_wren,
    output logic [14:0] vga_coord,
    output logic [8:0]  vga_colour,
    output logic        busy,
    output logic        overrun
);

    localparam int unsigned N_CLI    = 4;
    localparam int unsigned IDX_W    = 2;
    localparam int unsigned COORD_W  = 15;
    localparam int unsigned COLOUR_W = 9;
    localparam int unsigned HOLD_W   = 16;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_GRANT = 2'd1;
    localparam logic [1:0] S_GAP   = 2'd2;

    // Hold count seen in the last permitted GRANT cycle.
    localparam logic [HOLD_W-1:0] HOLD_LIMIT = MAX_HOLD - 16'd1;
    localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;

    logic [1:0]        state_q, state_d;
    logic [N_CLI-1:0]  grant_q, grant_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              overrun_q, overrun_d;

    logic              win_valid;
    logic [IDX_W-1:0]  win_idx;
    logic              in_grant;
    logic              owner_done;
    logic              owner_req;
    logic              wd_hit;
    logic              release_now;

    logic [COORD_W-1:0]  coord_arr  [N_CLI];
    logic [COLOUR_W-1:0] colour_arr [N_CLI];

    // Unpack the flat client buses into per-client fields.
    always_comb begin
        for (int i = 0; i < N_CLI; i++) begin
            coord_arr[i]  = cli_coord[COORD_W*i +: COORD_W];
            colour_arr[i] = cli_colour[COLOUR_W*i +: COLOUR_W];
        end
    end

    // Round-robin pick: first requester at or above ptr, wrapping 3 -> 0.
    always_comb begin
        logic [IDX_W-1:0] cand;
        win_valid = 1'b0;
        win_idx   = ptr_q;
        cand      = ptr_q;
        for (int i = 0; i < N_CLI; i++) begin
            cand = ptr_q + IDX_W'(i);
            if (!win_valid && req[cand]) begin
                win_valid = 1'b1;
                win_idx   = cand;
            end
        end
    end

    assign in_grant    = (state_q == S_GRANT);
    assign owner_done  = done[owner_q];
    assign owner_req   = req[owner_q];
    assign wd_hit      = (hold_q >= HOLD_LIMIT);
    assign release_now = owner_done || !owner_req || wd_hit;

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        owner_d   = owner_q;
        ptr_d     = ptr_q;
        hold_d    = hold_q;
        overrun_d = overrun_q;

        case (state_q)
            S_IDLE, S_GAP: begin
                if (win_valid) begin
                    state_d = S_GRANT;
                    owner_d = win_idx;
                    grant_d = 4'b0001 << win_idx;
                    hold_d  = '0;
                end else begin
                    state_d = S_IDLE;
                    grant_d = '0;
                end
            end
            S_GRANT: begin
                if (release_now) begin
                    state_d = S_GAP;
                    grant_d = '0;
                    ptr_d   = owner_q + 2'd1;
                    // A same-cycle done counts as a clean finish.
                    if (wd_hit && !owner_done) begin
                        overrun_d = 1'b1;
                    end
                end else if (hold_q != HOLD_SAT) begin
                    hold_d = hold_q + 16'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            grant_q   <= '0;
            owner_q   <= '0;
            ptr_q     <= '0;
            hold_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            owner_q   <= owner_d;
            ptr_q     <= ptr_d;
            hold_q    <= hold_d;
            overrun_q <= overrun_d;
        end
    end

    // Outputs. The VGA port is a zero-latency mux of the owner's signals; it
    // is gated by the state flop so reset blanks it without a clock edge.
    assign grant      = grant_q;
    assign busy       = (state_q != S_IDLE);
    assign overrun    = overrun_q;
    assign vga_wren   = in_grant & cli_wren[owner_q];
    assign vga_coord  = in_grant ? coord_arr[owner_q]  : '0;
    assign vga_colour = in_grant ? colour_arr[owner_q] : '0;

endmodule

// File: tb/tb_vga_draw_arbiter.sv
// Self-checking bench for vga_draw_arbiter (MAX_HOLD = 8): a table of
// single-cycle vectors, directed multi-cycle sequences, and a randomized run
// compared against a cycle-level ownership model.
module tb_vga_draw_arbiter;

    localparam int MH = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic [3:0]  req;
    logic [3:0]  done;
    logic [3:0]  cli_wren;
    logic [59:0] cli_coord;
    logic [35:0] cli_colour;
    logic [3:0]  grant;
    logic        vga_wren;
    logic [14:0] vga_coord;
    logic [8:0]  vga_colour;
    logic        busy;
    logic        overrun;

    vga_draw_arbiter #(.MAX_HOLD(16'd8)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .req        (req),
        .done       (done),
        .cli_wren   (cli_wren),
        .cli_coord  (cli_coord),
        .cli_colour (cli_colour),
        .grant      (grant),
        .vga_wren   (vga_wren),
        .vga_coord  (vga_coord),
        .vga_colour (vga_colour),
        .busy       (busy),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  done;
        logic [3:0]  wren;
        logic [3:0]  grant;
        logic        vwren;
        logic [14:0] coord;
        logic [8:0]  colour;
        logic        busy;
    } vec_t;

    vec_t tbl [9];

    // Reference model: who owns the port, whether we sit in the gap cycle,
    // the round-robin start point, cycles already held, sticky overrun.
    int   m_owner;
    bit   m_gap;
    int   m_ptr;
    int   m_held;
    bit   m_ovr;

    logic [3:0] rr_seq [5];
    int         rr_zero [5];
    logic [3:0] rr_exp [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input logic [3:0] r, input logic [3:0] d, input logic [3:0] w);
        @(negedge clk);
        req = r;
        done = d;
        cli_wren = w;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        req = '0;
        done = '0;
        cli_wren = '0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_owner = -1;
        m_gap   = 1'b0;
        m_ptr   = 0;
        m_held  = 0;
        m_ovr   = 1'b0;
    endfunction

    function automatic void model_step(input logic [3:0] r, input logic [3:0] d);
        int w;
        if (m_owner >= 0) begin
            m_held++;
            if (d[m_owner] || !r[m_owner] || m_held >= MH) begin
                if (m_held >= MH && !d[m_owner]) m_ovr = 1'b1;
                m_ptr   = (m_owner + 1) % 4;
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else begin
            m_gap = 1'b0;
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_held  = 0;
            end
        end
    endfunction

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int n;
        int zrun;
        int gcnt;
        logic [3:0] prev;
        logic [3:0] rq;
        logic [3:0] dn;
        logic [3:0] eg;
        logic       ew;
        logic [14:0] ec;
        logic [8:0]  ecol;

        resetn     = 1'b0;
        req        = '0;
        done       = '0;
        cli_wren   = '0;
        cli_coord  = {15'h0333, 15'h2A5A, 15'h1234, 15'h0111};
        cli_colour = {9'h003, 9'h0A5, 9'h1FF, 9'h001};

        tbl[0] = '{4'b0110, 4'b0000, 4'b0000, 4'b0000, 1'b0, 15'h0000, 9'h000, 1'b0};
        tbl[1] = '{4'b0110, 4'b0000, 4'b0110, 4'b0010, 1'b1, 15'h1234, 9'h1FF, 1'b1};
        tbl[2] = '{4'b0110, 4'b0100, 4'b0100, 4'b0010, 1'b0, 15'h1234, 9'h1FF, 1'b1};
        tbl[3] = '{4'b0110, 4'b0010, 4'b0010, 4'b0010, 1'b1, 15'h1234, 9'h1FF, 1'b1};
        tbl[4] = '{4'b0110, 4'b0000, 4'b0110, 4'b0000, 1'b0, 15'h0000, 9'h000, 1'b1};
        tbl[5] = '{4'b0110, 4'b0000, 4'b0110, 4'b0100, 1'b1, 15'h2A5A, 9'h0A5, 1'b1};
        tbl[6] = '{4'b0000, 4'b0000, 4'b0000, 4'b0100, 1'b0, 15'h2A5A, 9'h0A5, 1'b1};
        tbl[7] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 15'h0000, 9'h000, 1'b1};
        tbl[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 15'h0000, 9'h000, 1'b0};

        rr_exp[0] = 4'b0001;
        rr_exp[1] = 4'b0010;
        rr_exp[2] = 4'b0100;
        rr_exp[3] = 4'b1000;
        rr_exp[4] = 4'b0001;

        // Reset state with requests pending and client write enables high.
        req = 4'hF;
        cli_wren = 4'hF;
        repeat (2) @(negedge clk);
        check("rst_grant",   32'(grant), 32'h0);
        check("rst_busy",    32'(busy), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_wren",    32'(vga_wren), 32'h0);
        check("rst_coord",   32'(vga_coord), 32'h0);
        check("rst_colour",  32'(vga_colour), 32'h0);
        do_reset();

        // Table: arbitration, pass-through, non-owner masking, done, abort.
        for (int i = 0; i < 9; i++) begin
            apply(tbl[i].req, tbl[i].done, tbl[i].wren);
            check($sformatf("tbl%0d_grant", i),   32'(grant), 32'(tbl[i].grant));
            check($sformatf("tbl%0d_wren", i),    32'(vga_wren), 32'(tbl[i].vwren));
            check($sformatf("tbl%0d_coord", i),   32'(vga_coord), 32'(tbl[i].coord));
            check($sformatf("tbl%0d_colour", i),  32'(vga_colour), 32'(tbl[i].colour));
            check($sformatf("tbl%0d_busy", i),    32'(busy), 32'(tbl[i].busy));
            check($sformatf("tbl%0d_overrun", i), 32'(overrun), 32'h0);
        end

        // Round robin over all four clients, done on the third owned cycle.
        do_reset();
        n = 0;
        zrun = 0;
        gcnt = 0;
        prev = '0;
        for (int c = 0; c < 60 && n < 5; c++) begin
            apply(4'hF, 4'h0, 4'h0);
            if (grant != 4'h0) begin
                if (prev == 4'h0) begin
                    rr_seq[n]  = grant;
                    rr_zero[n] = zrun;
                    n++;
                    zrun = 0;
                    gcnt = 0;
                end
                gcnt++;
                if (gcnt == 3) done = grant;
            end else begin
                zrun++;
            end
            prev = grant;
        end
        check("rr_owner_count", 32'(n), 32'd5);
        for (int i = 0; i < n; i++) begin
            check($sformatf("rr_owner%0d", i), 32'(rr_seq[i]), 32'(rr_exp[i]));
            if (i > 0) check($sformatf("rr_gap%0d", i), 32'(rr_zero[i]), 32'd1);
        end

        // Watchdog: owner never finishes, then a later clean done.
        do_reset();
        apply(4'h1, 4'h0, 4'h0);
        check("wd_idle_grant", 32'(grant), 32'h0);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            apply(4'h1, 4'h0, 4'h0);
            if (grant != 4'h1) break;
            cnt++;
            if (cnt == MH) check("wd_no_overrun_yet", 32'(overrun), 32'h0);
        end
        check("wd_hold_cycles", 32'(cnt), 32'(MH));
        check("wd_gap_grant",   32'(grant), 32'h0);
        check("wd_overrun",     32'(overrun), 32'h1);
        check("wd_gap_busy",    32'(busy), 32'h1);
        apply(4'h1, 4'h0, 4'h0);
        check("wd_regrant", 32'(grant), 32'h1);
        apply(4'h1, 4'h1, 4'h0);
        check("wd_done_cycle", 32'(grant), 32'h1);
        apply(4'h1, 4'h0, 4'h0);
        check("wd_done_gap",       32'(grant), 32'h0);
        check("wd_overrun_sticky", 32'(overrun), 32'h1);

        // Asynchronous reset in the third cycle of a burst.
        do_reset();
        apply(4'h4, 4'h0, 4'h4);
        check("ar_idle", 32'(grant), 32'h0);
        apply(4'h4, 4'h0, 4'h4);
        apply(4'h4, 4'h0, 4'h4);
        apply(4'h4, 4'h0, 4'h4);
        check("ar_burst_grant", 32'(grant), 32'h4);
        check("ar_burst_wren",  32'(vga_wren), 32'h1);
        resetn = 1'b0;
        req = '0;
        #1;
        check("ar_grant_drop", 32'(grant), 32'h0);
        check("ar_wren_drop",  32'(vga_wren), 32'h0);
        check("ar_busy_drop",  32'(busy), 32'h0);
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        apply(4'h8, 4'h0, 4'h0);
        check("ar_post_idle", 32'(grant), 32'h0);
        apply(4'h8, 4'h0, 4'h0);
        check("ar_regrant", 32'(grant), 32'h8);

        // Owner aborts by dropping req; pointer must still advance.
        do_reset();
        apply(4'h3, 4'h0, 4'h0);
        apply(4'h3, 4'h0, 4'h0);
        check("ab_grant", 32'(grant), 32'h1);
        apply(4'h2, 4'h0, 4'h0);
        check("ab_hold", 32'(grant), 32'h1);
        apply(4'h3, 4'h0, 4'h0);
        check("ab_gap",     32'(grant), 32'h0);
        check("ab_overrun", 32'(overrun), 32'h0);
        apply(4'h3, 4'h0, 4'h0);
        check("ab_ptr", 32'(grant), 32'h2);

        // Randomized run against the model.
        do_reset();
        model_reset();
        rq = '0;
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) rq = 4'($urandom);
            dn = ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'h0;
            req        = rq;
            done       = dn;
            cli_wren   = 4'($urandom);
            cli_coord  = 60'({$urandom, $urandom});
            cli_colour = 36'({$urandom, $urandom});
            #1;
            if (m_owner >= 0) begin
                eg   = 4'(1 << m_owner);
                ew   = cli_wren[m_owner];
                ec   = cli_coord[15*m_owner +: 15];
                ecol = cli_colour[9*m_owner +: 9];
            end else begin
                eg   = '0;
                ew   = 1'b0;
                ec   = '0;
                ecol = '0;
            end
            check("rnd_grant",   32'(grant), 32'(eg));
            check("rnd_onehot",  32'($countones(grant) <= 1), 32'h1);
            check("rnd_wren",    32'(vga_wren), 32'(ew));
            check("rnd_coord",   32'(vga_coord), 32'(ec));
            check("rnd_colour",  32'(vga_colour), 32'(ecol));
            check("rnd_busy",    32'(busy), 32'((m_owner >= 0) || m_gap));
            check("rnd_overrun", 32'(overrun), 32'(m_ovr));
            @(posedge clk);
            model_step(rq, dn);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
